// File: rtl/zaq_regbus_pkg.sv
// Shared definitions for the register-bus arbiter: FSM states, idle bus
// levels and default address/data widths.
package zaq_regbus_pkg;

    localparam int DEF_AW = 5;
    localparam int DEF_DW = 32;

    // Idle levels of the single-bit bus controls; bus_addr and bus_din idle at zero.
    localparam logic BUS_WRB_IDLE = 1'b1;
    localparam logic BUS_RDB_IDLE = 1'b1;
    localparam logic BUS_DBL_IDLE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

endpackage

// File: rtl/zaq_rr_pick.sv
// Combinational round-robin picker: the first valid requester found when
// scanning upward from ptr (wrapping at N) wins.
module zaq_rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] win_idx,
    output logic          any
);

    // Scan offsets 0..N-1 from ptr and latch onto the first valid requester.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && valid[j] && (((int'(ptr) + i) % N) == j)) begin
                    any      = 1'b1;
                    grant[j] = 1'b1;
                    win_idx  = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/zaq_regbus_arb.sv
// Register-bus arbiter: NREQ requesters share one register bus, one
// transaction at a time. Accept (IDLE) -> strobe (WR/RD) -> response (RSP).
// Optional build macro REGBUS_ARB_LOCK_EN adds req_lock, letting an owner
// keep the round-robin pointer on itself for back-to-back grants.
module zaq_regbus_arb
    import zaq_regbus_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [NREQ-1:0]        req_dbl,
`ifdef REGBUS_ARB_LOCK_EN
    input  logic [NREQ-1:0]        req_lock,
`endif
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*2*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DW-1:0]          rsp_rdata,
    output logic                   bus_wrb,
    output logic                   bus_rdb,
    output logic [AW-1:0]          bus_addr,
    output logic [2*DW-1:0]        bus_din,
    output logic                   bus_dbl,
    input  logic [DW-1:0]          bus_dout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   own_idx;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   win_idx;
    logic            any;
`ifdef REGBUS_ARB_LOCK_EN
    logic            lock_held;
`endif

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    zaq_rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .valid   (req_valid),
        .ptr     (rr_ptr),
        .grant   (grant),
        .win_idx (win_idx),
        .any     (any)
    );

    // Acceptance is only offered while idle, so a request dropped earlier is simply never seen.
    assign req_ready = (state == IDLE) ? grant : '0;

    // Transaction FSM; the bus registers double as the captured request fields.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            own_idx   <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            bus_wrb   <= BUS_WRB_IDLE;
            bus_rdb   <= BUS_RDB_IDLE;
            bus_addr  <= '0;
            bus_din   <= '0;
            bus_dbl   <= BUS_DBL_IDLE;
`ifdef REGBUS_ARB_LOCK_EN
            lock_held <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        own_idx  <= win_idx;
                        bus_addr <= req_addr[win_idx*AW +: AW];
`ifdef REGBUS_ARB_LOCK_EN
                        rr_ptr    <= req_lock[win_idx] ? win_idx : nxt(win_idx);
                        lock_held <= req_lock[win_idx];
`else
                        rr_ptr   <= nxt(win_idx);
`endif
                        if (req_wr[win_idx]) begin
                            state   <= WR;
                            bus_wrb <= 1'b0;
                            bus_din <= req_wdata[win_idx*2*DW +: 2*DW];
                            bus_dbl <= req_dbl[win_idx];
                        end else begin
                            state   <= RD;
                            bus_rdb <= 1'b0;
                        end
                    end
`ifdef REGBUS_ARB_LOCK_EN
                    // Nobody is asking, so the owner is not either: hand the pointer on.
                    else if (lock_held) begin
                        lock_held <= 1'b0;
                        rr_ptr    <= nxt(own_idx);
                    end
`endif
                end
                WR: begin
                    state     <= RSP;
                    bus_wrb   <= BUS_WRB_IDLE;
                    bus_addr  <= '0;
                    bus_din   <= '0;
                    bus_dbl   <= BUS_DBL_IDLE;
                    rsp_valid <= NREQ'(1) << own_idx;
                    rsp_rdata <= '0;
                end
                RD: begin
                    state     <= RSP;
                    bus_rdb   <= BUS_RDB_IDLE;
                    bus_addr  <= '0;
                    rsp_valid <= NREQ'(1) << own_idx;
                    rsp_rdata <= bus_dout;
                end
                RSP: begin
                    state     <= IDLE;
                    rsp_valid <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zaq_regbus_arb.sv
// Self-checking bench for zaq_regbus_arb (NREQ=3, AW=5, DW=32).
// Expected responses go into a scoreboard when a request is driven and are
// popped when rsp_valid fires. Build with REGBUS_ARB_LOCK_EN to cover locking.
module tb_zaq_regbus_arb;

    logic         sysclk = 1'b0;
    logic         reset;
    logic [2:0]   req_valid, req_ready, req_wr, req_dbl, rsp_valid;
`ifdef REGBUS_ARB_LOCK_EN
    logic [2:0]   req_lock;
`endif
    logic [14:0]  req_addr;
    logic [191:0] req_wdata;
    logic [31:0]  rsp_rdata, bus_dout, dout_val;
    logic         bus_wrb, bus_rdb, bus_dbl;
    logic [4:0]   bus_addr;
    logic [63:0]  bus_din;

    typedef struct { int idx; logic [31:0] data; } exp_t;
    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic prev_low = 1'b0;

    assign bus_dout = dout_val;

    always #5 sysclk = ~sysclk;

    zaq_regbus_arb #(.NREQ(3), .AW(5), .DW(32)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_dbl   (req_dbl),
`ifdef REGBUS_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .bus_wrb   (bus_wrb),
        .bus_rdb   (bus_rdb),
        .bus_addr  (bus_addr),
        .bus_din   (bus_din),
        .bus_dbl   (bus_dbl),
        .bus_dout  (bus_dout)
    );

    // Scoreboard: each response must match the oldest outstanding expectation.
    always @(negedge sysclk) begin
        if (!reset && rsp_valid !== 3'b000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=%b rsp_rdata=%h, none expected", rsp_valid, rsp_rdata);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== (3'b001 << e.idx) || rsp_rdata !== e.data) begin
                    errors++;
                    $display("FAIL rsp_match: got valid=%b data=%h, want valid=%b data=%h",
                             rsp_valid, rsp_rdata, 3'b001 << e.idx, e.data);
                end
            end
        end
    end

    // Strobes: never both low, never low in two adjacent cycles.
    always @(negedge sysclk) begin
        if (!bus_wrb || !bus_rdb) begin
            checks++;
            if (!bus_wrb && !bus_rdb) begin
                errors++;
                $display("FAIL strobe_overlap: wrb=%b rdb=%b, want not both low", bus_wrb, bus_rdb);
            end else if (prev_low) begin
                errors++;
                $display("FAIL strobe_adjacent: strobe low two cycles running, want a gap");
            end
        end
        prev_low <= !bus_wrb || !bus_rdb;
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] data);
        exp_t x;
        x.idx  = idx;
        x.data = data;
        sb.push_back(x);
    endtask

    task automatic set_req(input int i, input logic wr, input logic dbl,
                           input logic [4:0] a, input logic [63:0] d);
        req_valid[i]         = 1'b1;
        req_wr[i]            = wr;
        req_dbl[i]           = dbl;
        req_addr[i*5 +: 5]   = a;
        req_wdata[i*64 +: 64] = d;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        @(negedge sysclk);
        checks++;
        if (bus_wrb !== 1'b1 || bus_rdb !== 1'b1 || bus_addr !== 5'h0 || bus_din !== 64'h0 || bus_dbl !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: wrb=%b rdb=%b addr=%h din=%h dbl=%b, want 1 1 0 0 0",
                     bus_wrb, bus_rdb, bus_addr, bus_din, bus_dbl);
        end
        checks++;
        if (req_ready !== 3'b000 || rsp_valid !== 3'b000 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b rdata=%h, want 0 0 0", req_ready, rsp_valid, rsp_rdata);
        end
        @(posedge sysclk);
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 1'b0, 5'h07, {32'h0, 32'hA5A5_0001});
        push_exp(0, 32'h0);
        @(negedge sysclk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL wr_ready: got %b, want 001", req_ready);
        end
        tick();
        req_valid = 3'b000;
        @(negedge sysclk);
        checks++;
        if (bus_wrb !== 1'b0 || bus_rdb !== 1'b1 || bus_addr !== 5'h07 || bus_din !== {32'h0, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL wr_strobe: wrb=%b rdb=%b addr=%h din=%h, want 0 1 07 00000000a5a50001",
                     bus_wrb, bus_rdb, bus_addr, bus_din);
        end
        tick();
        @(negedge sysclk);
        checks++;
        if (rsp_valid !== 3'b001 || rsp_rdata !== 32'h0 || bus_wrb !== 1'b1) begin
            errors++;
            $display("FAIL wr_rsp: rsp_valid=%b rdata=%h wrb=%b, want 001 0 1", rsp_valid, rsp_rdata, bus_wrb);
        end
        tick();
    endtask

    task automatic test_read();
        dout_val = 32'h1234_5678;
        set_req(1, 1'b0, 1'b0, 5'h0A, 64'h0);
        push_exp(1, 32'h1234_5678);
        @(negedge sysclk);
        checks++;
        if (req_ready !== 3'b010) begin
            errors++; $display("FAIL rd_ready: got %b, want 010", req_ready);
        end
        tick();
        req_valid = 3'b000;
        @(negedge sysclk);
        checks++;
        if (bus_rdb !== 1'b0 || bus_wrb !== 1'b1 || bus_addr !== 5'h0A) begin
            errors++;
            $display("FAIL rd_strobe: rdb=%b wrb=%b addr=%h, want 0 1 0a", bus_rdb, bus_wrb, bus_addr);
        end
        tick();
        @(negedge sysclk);
        checks++;
        if (rsp_valid !== 3'b010 || rsp_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_rsp: rsp_valid=%b rdata=%h, want 010 12345678", rsp_valid, rsp_rdata);
        end
        tick();
        dout_val = 32'hFFFF_0000;
        tick();
        @(negedge sysclk);
        checks++;
        if (rsp_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL rd_hold: rdata=%h, want 12345678", rsp_rdata);
        end
        tick();
    endtask

    task automatic test_dbl();
        set_req(2, 1'b1, 1'b1, 5'h10, 64'hDEAD_BEEF_CAFE_F00D);
        push_exp(2, 32'h0);
        @(negedge sysclk);
        tick();
        req_valid = 3'b000;
        @(negedge sysclk);
        checks++;
        if (bus_wrb !== 1'b0 || bus_dbl !== 1'b1 || bus_addr !== 5'h10 || bus_din !== 64'hDEAD_BEEF_CAFE_F00D) begin
            errors++;
            $display("FAIL dbl_wr: wrb=%b dbl=%b addr=%h din=%h, want 0 1 10 deadbeefcafef00d",
                     bus_wrb, bus_dbl, bus_addr, bus_din);
        end
        tick();
        tick();
        dout_val = 32'h0BAD_F00D;
        set_req(0, 1'b0, 1'b1, 5'h10, 64'h1111_2222_3333_4444);
        push_exp(0, 32'h0BAD_F00D);
        tick();
        req_valid = 3'b000;
        @(negedge sysclk);
        checks++;
        if (bus_rdb !== 1'b0 || bus_dbl !== 1'b0 || bus_din !== 64'h0) begin
            errors++;
            $display("FAIL dbl_rd: rdb=%b dbl=%b din=%h, want 0 0 0", bus_rdb, bus_dbl, bus_din);
        end
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        int          n;
        int          gc[4];
        logic [2:0]  gg[4];
        int          exp_o[4] = '{0, 1, 2, 0};
        pulse_reset();
        dout_val = 32'h5555_AAAA;
        set_req(0, 1'b0, 1'b0, 5'h01, 64'h0);
        set_req(1, 1'b0, 1'b0, 5'h02, 64'h0);
        set_req(2, 1'b0, 1'b0, 5'h03, 64'h0);
        n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge sysclk);
            if (req_ready !== 3'b000) begin
                gc[n] = c;
                gg[n] = req_ready;
                push_exp(exp_o[n], dout_val);
                n++;
            end
            tick();
        end
        req_valid = 3'b000;
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL rr_timeout: saw %0d grants, want 4", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (gg[k] !== (3'b001 << exp_o[k])) begin
                errors++; $display("FAIL rr_order[%0d]: grant=%b, want %b", k, gg[k], 3'b001 << exp_o[k]);
            end
        end
        for (int k = 1; k < n; k++) begin
            checks++;
            if (gc[k] - gc[k-1] != 3) begin
                errors++; $display("FAIL rr_spacing[%0d]: gap=%0d, want 3", k, gc[k] - gc[k-1]);
            end
        end
        repeat (4) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL rr_drain: %0d responses outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_wr();
        set_req(1, 1'b1, 1'b0, 5'h03, 64'h1);
        @(negedge sysclk);
        tick();
        req_valid = 3'b000;
        @(negedge sysclk);
        checks++;
        if (bus_wrb !== 1'b0) begin
            errors++; $display("FAIL mid_pre: wrb=%b, want 0", bus_wrb);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus_wrb !== 1'b1 || bus_addr !== 5'h0 || bus_din !== 64'h0) begin
            errors++;
            $display("FAIL mid_abort: wrb=%b addr=%h din=%h, want 1 0 0", bus_wrb, bus_addr, bus_din);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge sysclk);
            checks++;
            if (rsp_valid !== 3'b000) begin
                errors++; $display("FAIL mid_norsp: rsp_valid=%b, want 000", rsp_valid);
            end
            tick();
        end
        dout_val = 32'h0000_00C3;
        set_req(0, 1'b0, 1'b0, 5'h00, 64'h0);
        set_req(1, 1'b0, 1'b0, 5'h01, 64'h0);
        set_req(2, 1'b0, 1'b0, 5'h02, 64'h0);
        push_exp(0, 32'h0000_00C3);
        @(negedge sysclk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL mid_next: grant=%b, want 001", req_ready);
        end
        tick();
        req_valid = 3'b000;
        repeat (3) tick();
    endtask

    task automatic test_withdraw();
        set_req(0, 1'b1, 1'b0, 5'h04, 64'h44);
        push_exp(0, 32'h0);
        @(negedge sysclk);
        tick();
        req_valid = 3'b000;
        req_addr[4:0]   = 5'h1F;
        req_wdata[63:0] = 64'h99;
        set_req(2, 1'b0, 1'b0, 5'h05, 64'h0);
        @(negedge sysclk);
        checks++;
        if (bus_addr !== 5'h04 || bus_din !== 64'h44 || req_ready !== 3'b000) begin
            errors++;
            $display("FAIL wd_ignore: addr=%h din=%h ready=%b, want 04 44 000", bus_addr, bus_din, req_ready);
        end
        tick();
        req_valid = 3'b000;
        @(negedge sysclk);
        tick();
        @(negedge sysclk);
        checks++;
        if (req_ready !== 3'b000) begin
            errors++; $display("FAIL wd_withdrawn: ready=%b, want 000", req_ready);
        end
        repeat (3) tick();
    endtask

`ifdef REGBUS_ARB_LOCK_EN
    task automatic test_lock();
        int          n;
        logic [2:0]  gg[4];
        int          exp_o[4] = '{2, 2, 2, 0};
        pulse_reset();
        dout_val = 32'h0000_10CC;
        set_req(2, 1'b0, 1'b0, 5'h06, 64'h0);
        req_lock = 3'b100;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge sysclk);
            if (req_ready !== 3'b000) begin
                gg[n] = req_ready;
                push_exp(exp_o[n], dout_val);
                n++;
            end
            tick();
            if (n == 1) set_req(0, 1'b0, 1'b0, 5'h08, 64'h0);
            if (n == 2) req_lock = 3'b000;
            if (n == 3) req_valid[2] = 1'b0;
            if (n == 4) req_valid = 3'b000;
        end
        req_valid = 3'b000;
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL lock_timeout: saw %0d grants, want 4", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (gg[k] !== (3'b001 << exp_o[k])) begin
                errors++; $display("FAIL lock_order[%0d]: grant=%b, want %b", k, gg[k], 3'b001 << exp_o[k]);
            end
        end
        repeat (4) tick();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        req_valid = 3'b000;
        req_wr    = 3'b000;
        req_dbl   = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        dout_val  = 32'h0;
`ifdef REGBUS_ARB_LOCK_EN
        req_lock  = 3'b000;
`endif
        test_reset();
        test_single_write();
        test_read();
        test_dbl();
        test_round_robin();
        test_reset_mid_wr();
        test_withdraw();
`ifdef REGBUS_ARB_LOCK_EN
        test_lock();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL final_drain: %0d responses never arrived", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
